// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Adds two WIDTH-bit operands by driving one external 4-bit adder slice,
// one nibble per clock, least significant nibble first. The ripple carry is
// held in a register between cycles and the slice results are shifted into
// the sum register from the MSB side, so after NIB steps the full sum sits
// in place.
//
// Handshake: start is accepted on a rising edge only while ready=1 (IDLE).
// A start seen while busy=1 is ignored; nothing is queued. done pulses for
// exactly one cycle when sum/cout become valid; sum/cout then hold until the
// next accepted start.
//
// Optional build macro NIBBLE_ADD_SUB_EN: adds input 'sub'. With sub=1 the
// B operand is inverted on load and the initial carry is forced to 1, so the
// result is A-B and cout=1 means "no borrow".
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   sub                 (NIBBLE_ADD_SUB_EN only) subtract select
//   start               request, accepted when ready=1
//   op_a, op_b, cin_in  operands and initial carry, sampled on accept
//   ready, busy, done   status: IDLE / RUN or DONE / one-cycle result pulse
//   sum, cout           result register and final carry
//   slice_a/b/cin       nibbles and carry driven to the external adder slice
//   slice_sum/cout      combinational return from the adder slice
//   state_dbg           current FSM state encoding (0=IDLE,1=RUN,2=DONE)
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef NIBBLE_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [3:0]       slice_a,
   output logic [3:0]       slice_b,
   output logic             slice_cin,
   input  logic [3:0]       slice_sum,
   input  logic             slice_cout,
   output logic [1:0]       state_dbg
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             carry;
   logic [CW-1:0]    count;
   logic             load, step, last;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;

   // Operand conditioning at accept time.
`ifdef NIBBLE_ADD_SUB_EN
   // Two's-complement subtract: A + ~B + 1.
   assign b_load   = sub ? ~op_b : op_b;
   assign cin_load = sub ? 1'b1  : cin_in;
`else
   assign b_load   = op_b;
   assign cin_load = cin_in;
`endif

   assign last = (count == CW'(NIB - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and control decode
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: shift registers, carry, sum assembly, nibble counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         count <= '0;
      end else if (load) begin
         a_reg <= op_a;
         b_reg <= b_load;
         carry <= cin_load;
         sum   <= '0;
         cout  <= 1'b0;
         count <= '0;
      end else if (step) begin
         // After NIB shifts the first slice result has reached bits [3:0].
         sum   <= {slice_sum, sum[WIDTH-1:4]};
         carry <= slice_cout;
         a_reg <= a_reg >> 4;
         b_reg <= b_reg >> 4;
         count <= count + CW'(1);
         if (last) cout <= slice_cout;
      end
   end

   // Outputs decoded from registered state only; slice inputs are quiet
   // outside RUN so the shared adder sees zeros when not in use.
   assign ready     = (state == IDLE);
   assign busy      = (state == RUN) || (state == DONE);
   assign done      = (state == DONE);
   assign slice_a   = (state == RUN) ? a_reg[3:0] : 4'd0;
   assign slice_b   = (state == RUN) ? b_reg[3:0] : 4'd0;
   assign slice_cin = (state == RUN) ? carry      : 1'b0;
   assign state_dbg = state;

endmodule
